// File: rtl/two_char_to_num.sv
// Builds a two-digit decimal value from a tens and then a ones ASCII digit, and range-checks it.
// Outputs are registered one cycle after the deciding strobe; there is no backpressure (single-cycle strobes).
module two_char_to_num #(
  parameter int unsigned MAX_VAL = 59,
  parameter int unsigned TIMEOUT = 50000000,
  parameter int unsigned CNT_W   = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  input  logic       clear,
  output logic [6:0] number,
  output logic       num_valid,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_ONE = 1'b1
  } state_t;

  localparam logic [1:0]       ERR_NONDIGIT = 2'b01;
  localparam logic [1:0]       ERR_RANGE    = 2'b10;
  localparam logic [1:0]       ERR_TIMEOUT  = 2'b11;
  localparam logic [6:0]       MAX_V        = 7'(MAX_VAL);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit               TIMEOUT_EN   = (TIMEOUT != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_tens;
  logic [3:0]       w_tens_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [6:0]       r_number;
  logic [6:0]       w_number_nxt;
  logic             r_num_valid;
  logic             w_num_valid_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic [1:0]       r_err_code;
  logic [1:0]       w_err_code_nxt;

  logic             w_is_digit;
  logic             w_is_bksp;
  logic [6:0]       w_sum;
  logic             w_in_range;
  logic             w_timeout;

  assign w_is_digit = (char_data[7:4] == 4'h3) && (char_data[3:0] <= 4'd9);
  assign w_is_bksp  = (char_data == 8'h08);
  // tens*10 as tens*8 + tens*2; the largest result is 99 so 7 bits never overflow
  assign w_sum      = {r_tens, 3'b000} + {2'b00, r_tens, 1'b0} + {3'b000, char_data[3:0]};
  assign w_in_range = (w_sum <= MAX_V);
  assign w_timeout  = TIMEOUT_EN && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (char_valid && w_is_digit) begin
            w_state_nxt = S_WAIT_ONE;
          end
        end
        S_WAIT_ONE: begin
          if (char_valid || w_timeout) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A character in the same cycle as the timeout takes priority over it
  always_comb begin
    w_tens_nxt      = r_tens;
    w_cnt_nxt       = r_cnt;
    w_number_nxt    = r_number;
    w_num_valid_nxt = 1'b0;
    w_err_nxt       = 1'b0;
    w_err_code_nxt  = r_err_code;
    if (clear) begin
      w_tens_nxt = 4'd0;
      w_cnt_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (char_valid) begin
            if (w_is_digit) begin
              w_tens_nxt = char_data[3:0];
              w_cnt_nxt  = '0;
            end else if (!w_is_bksp) begin
              w_err_nxt      = 1'b1;
              w_err_code_nxt = ERR_NONDIGIT;
            end
          end
        end
        S_WAIT_ONE: begin
          if (char_valid) begin
            w_cnt_nxt = '0;
            if (w_is_digit) begin
              if (w_in_range) begin
                w_number_nxt    = w_sum;
                w_num_valid_nxt = 1'b1;
              end else begin
                w_err_nxt      = 1'b1;
                w_err_code_nxt = ERR_RANGE;
              end
            end else if (w_is_bksp) begin
              w_tens_nxt = 4'd0;
            end else begin
              w_err_nxt      = 1'b1;
              w_err_code_nxt = ERR_NONDIGIT;
            end
          end else if (w_timeout) begin
            w_cnt_nxt      = '0;
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ERR_TIMEOUT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_tens_nxt = 4'd0;
          w_cnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens      <= 4'd0;
      r_cnt       <= '0;
      r_number    <= 7'd0;
      r_num_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_tens      <= w_tens_nxt;
      r_cnt       <= w_cnt_nxt;
      r_number    <= w_number_nxt;
      r_num_valid <= w_num_valid_nxt;
      r_err       <= w_err_nxt;
      r_err_code  <= w_err_code_nxt;
    end
  end

  always_comb begin
    busy      = (r_state == S_WAIT_ONE);
    number    = r_number;
    num_valid = r_num_valid;
    err       = r_err;
    err_code  = r_err_code;
  end

endmodule

// File: tb/tb_two_char_to_num.sv
// Directed bench for two_char_to_num: stimulus pushes expected pulses, a negedge monitor pops and compares.
module tb_two_char_to_num;

  logic       clk;
  logic       rst_n;
  logic       char_valid;
  logic [7:0] char_data;
  logic       clear;
  logic [6:0] number;
  logic       num_valid;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  typedef struct packed {
    logic       is_err;
    logic [6:0] val;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_vec;
  int   n_err;

  two_char_to_num #(
    .MAX_VAL(59),
    .TIMEOUT(10),
    .CNT_W  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_valid(char_valid),
    .char_data (char_data),
    .clear     (clear),
    .number    (number),
    .num_valid (num_valid),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one strobe; returns 1 time unit after the edge that sampled it
  task automatic send(input logic [7:0] ch);
    char_valid = 1'b1;
    char_data  = ch;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_data  = 8'h00;
  endtask

  task automatic exp_push(input logic is_err, input logic [6:0] v, input int dly);
    exp_t e;
    e.is_err = is_err;
    e.val    = v;
    e.cyc    = cyc + dly;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (num_valid && err) begin
        n_vec++;
        n_err++;
        $display("FAIL exclusive: num_valid and err both high at cycle %0d", cyc);
      end
      if (num_valid || err) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected pulse: num_valid=%0b err=%0b number=%0d code=%0d cycle=%0d",
                   num_valid, err, number, err_code, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pulse kind (err)", int'(err), int'(e.is_err));
          check(e.is_err ? "err_code" : "number", e.is_err ? int'(err_code) : int'(number), int'(e.val));
          check("pulse cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    clear      = 1'b0;
    #1;
    check("reset number", int'(number), 0);
    check("reset num_valid", int'(num_valid), 0);
    check("reset err", int'(err), 0);
    check("reset err_code", int'(err_code), 0);
    check("reset busy", int'(busy), 0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // "47" accepted
    send(8'h34);
    check("busy after tens", int'(busy), 1);
    send(8'h37);
    exp_push(1'b0, 7'd47, 0);
    check("busy after ones", int'(busy), 0);
    idle(2);
    check("number holds 47", int'(number), 47);

    // "60" exceeds 59
    send(8'h36);
    send(8'h30);
    exp_push(1'b1, 7'd2, 0);
    idle(2);
    check("number kept after range err", int'(number), 47);
    check("idle after range err", int'(busy), 0);

    // "2A" non-digit in ones position, then "05" back-to-back
    send(8'h32);
    send(8'h41);
    exp_push(1'b1, 7'd1, 0);
    check("busy falls on non-digit", int'(busy), 0);
    send(8'h30);
    send(8'h35);
    exp_push(1'b0, 7'd5, 0);
    idle(2);

    // timeout after 10 idle cycles
    send(8'h33);
    exp_push(1'b1, 7'd3, 10);
    idle(10);
    check("busy after timeout", int'(busy), 0);
    idle(1);
    // ones digit lands on the cycle the timeout would fire: character wins
    send(8'h33);
    idle(9);
    check("busy before late ones", int'(busy), 1);
    send(8'h31);
    exp_push(1'b0, 7'd31, 0);
    idle(2);

    // backspace drops tens, then "59" is the largest accepted value
    send(8'h31);
    send(8'h08);
    check("busy after backspace", int'(busy), 0);
    send(8'h35);
    send(8'h39);
    exp_push(1'b0, 7'd59, 0);
    idle(2);

    // clear coincident with "2" drops the character
    send(8'h31);
    clear      = 1'b1;
    char_valid = 1'b1;
    char_data  = 8'h32;
    @(posedge clk);
    #1;
    clear      = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    check("busy after clear", int'(busy), 0);
    idle(3);
    check("number after clear", int'(number), 59);

    // backspace in IDLE is silent; "99" out of range; ':' and '/' bracket the digits
    send(8'h08);
    check("busy after idle backspace", int'(busy), 0);
    send(8'h39);
    send(8'h39);
    exp_push(1'b1, 7'd2, 0);
    send(8'h3A);
    exp_push(1'b1, 7'd1, 0);
    send(8'h2F);
    exp_push(1'b1, 7'd1, 0);
    idle(2);

    // asynchronous reset mid-entry
    send(8'h37);
    check("busy before reset", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst number", int'(number), 0);
    check("async rst num_valid", int'(num_valid), 0);
    check("async rst err", int'(err), 0);
    check("async rst err_code", int'(err_code), 0);
    check("async rst busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    send(8'h30);
    send(8'h30);
    exp_push(1'b0, 7'd0, 0);
    idle(5);
    check("expected pulses all seen", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/two_char_to_num.md
Name: two_char_to_num

Overview:
- Assembles a two-digit decimal number from two ASCII digit characters (tens first, then ones) arriving one per strobe from the keypad/UART time-entry path.
- Range-checks the result against a programmable maximum and emits a one-cycle valid pulse with the 7-bit value.
- Output feeds the clock's hour/minute/second set registers.
- Performs the inverse of the number-to-two-character display conversion.

Parameters:
- MAX_VAL, 59, largest accepted result (legal range 1..99); larger results are rejected.
- TIMEOUT, 50000000, clk cycles allowed between tens and ones characters; 0 disables the timeout.
- CNT_W, 26, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- char_valid  input  1  char_data is valid this cycle; single-cycle strobe, no backpressure.
- char_data  input  8  ASCII character.
- clear  input  1  synchronous abort; discards any partial entry.
- number  output  7  last accepted value, tens*10+ones.
- num_valid  output  1  one-cycle pulse; number updated this cycle.
- err  output  1  one-cycle pulse on rejected entry.
- err_code  output  2  reason, valid when err=1: 01 non-digit, 10 out of range, 11 timeout; holds last code otherwise.
- busy  output  1  high while the tens digit is held and the ones digit is awaited.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, number=0, num_valid=0, err=0, err_code=00, busy=0, tens register=0, timeout counter=0. Release is synchronous to clk.
- Digit: char_data in 0x30..0x39; digit value = char_data[3:0]. Backspace: 0x08. Every other code is a non-digit.
- States: IDLE, WAIT_ONE. busy=1 exactly when state=WAIT_ONE.
- IDLE, char_valid with digit: latch tens=digit, go to WAIT_ONE, clear counter.
- IDLE, char_valid with backspace: ignored, no pulse.
- IDLE, char_valid with other non-digit: err=1, err_code=01 on the next cycle; stay in IDLE.
- WAIT_ONE, char_valid with digit: compute sum=tens*10+digit in 7 bits (max 99, no overflow).
  - sum<=MAX_VAL: number=sum and num_valid=1 on the next edge.
  - Otherwise: err=1, err_code=10, number unchanged.
  - Either way, return to IDLE.
- WAIT_ONE, backspace: return to IDLE, tens=0, no pulse.
- WAIT_ONE, other non-digit: err, code 01, return to IDLE.
- WAIT_ONE, no char_valid: counter increments each cycle.
  - When counter reaches TIMEOUT-1: err, code 11, return to IDLE.
  - Only when TIMEOUT!=0.
- Latency: num_valid/err are registered and assert in the cycle after the clk edge that samples the final char_valid. They are high for exactly one cycle.
- number holds its value between accepts; num_valid and err are never high together.
- clear=1: state=IDLE, tens=0, counter=0, no pulse. A char_valid in the same cycle is dropped (clear wins). number is unchanged.
- Back-to-back strobes on consecutive cycles are fully supported, and a new entry may start in the same cycle num_valid is high.
- Timeout and char_valid in the same cycle: the character wins, no timeout error.
- "00" is a valid entry (number=0, num_valid=1).

Test Plan:
- Reset, then "4","7" (0x34,0x37) with MAX_VAL=59 -> number=47, num_valid one cycle after second strobe, err=0.
- "6","0" with MAX_VAL=59 -> err pulse, err_code=10, number keeps previous 47, state IDLE.
- "2",0x41 ('A') -> err, code 01, busy falls. Next "0","5" on consecutive cycles -> number=5, num_valid.
- TIMEOUT=10: "3", then idle 10 cycles -> err code 11 after the 10th idle cycle, busy=0. "3" then "1" at idle cycle 9 -> number=31, no err.
- "1", backspace, "5","9" -> number=59. Also "1" then clear coincident with "2" -> no pulse, busy=0, "2" dropped.
- Assert rst_n=0 mid-entry (busy=1) -> all outputs 0 immediately without a clk edge. After release, "0","0" -> number=0, num_valid=1.
